// File: rtl/kpd_pkg.sv
// kpd_pkg: shared definitions for the keypad scanner and related scanned
// peripherals.
//   - Matrix geometry constants (KPD_ROWS, KPD_COLS) and key code width (KEY_W).
//   - kpd_frame_res_e : classification of one complete scan frame.
//   - kpd_state_e     : debounce FSM state, also exported on the debug port.
//   - count_low / lowest_low : helpers for active-low column vectors.
package kpd_pkg;

  localparam int KPD_ROWS = 4;
  localparam int KPD_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } kpd_frame_res_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } kpd_state_e;

  // Number of asserted (low) lines in an active-low column vector.
  function automatic logic [2:0] count_low(input logic [KPD_COLS-1:0] cols_n);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < KPD_COLS; i++) begin
      n = n + {2'b00, ~cols_n[i]};
    end
    return n;
  endfunction

  // Index of the lowest-numbered low column; 0 when none is low.
  function automatic logic [1:0] lowest_low(input logic [KPD_COLS-1:0] cols_n);
    logic [1:0] idx;
    idx = '0;
    for (int i = KPD_COLS - 1; i >= 0; i--) begin
      if (!cols_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kpd_tick_gen.sv
// kpd_tick_gen: free-running prescaler producing a one-cycle strobe every
// DIV clocks. Usable by any scanned peripheral (keypad, display mux, ...).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous, active-low reset (prescaler returns to 0)
//   tick - high for one cycle when the prescaler is at DIV-1
module kpd_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;

  assign tick = (presc_q == PW'(DIV - 1));

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with whole-frame debouncing.
// Drives one row low at a time, samples the synchronised active-low columns
// at the end of each row slot, classifies each full 4-row frame as NONE, a
// single KEY or MULTI (chord/ghost), and debounces press and release over
// DEBOUNCE_FRAMES identical frames.
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous, active-low reset
//   col       - keypad columns, active-low, asynchronous to clk
//   row       - keypad row drive, active-low, one-hot-low
//   key_code  - last accepted key, {row_idx, col_idx}
//   key_valid - one-cycle pulse on each accepted press
//   key_down  - high while an accepted key is held
//   dbg_state - current debounce FSM state (observation only)
// DIV = CLK_FREQ/SCAN_FREQ must be >= 4; DEBOUNCE_FRAMES must be >= 1.
module keypad_scan
  import kpd_pkg::*;
#(
  parameter int CLK_FREQ        = 100_000_000,
  parameter int SCAN_FREQ       = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       col,
  output logic [3:0]       row,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_down,
  output kpd_state_e       dbg_state
);

  localparam int DIV   = CLK_FREQ / SCAN_FREQ;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_FRAMES);

  // ---------------------------------------------------------------- tick
  logic tick;

  kpd_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // --------------------------------------------------------- synchroniser
  logic [3:0] col_meta_q, col_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= col;
      col_s_q    <= col_meta_q;
    end
  end

  // ------------------------------------------------------------- row scan
  logic [1:0] row_idx_q, row_idx_d;

  assign row_idx_d = tick ? row_idx_q + 2'd1 : row_idx_q;
  assign row       = ~(4'b0001 << row_idx_q);

  // ------------------------------------------------------ frame accumulate
  // hits saturates at 2: anything beyond one hit is already MULTI.
  logic [1:0]       hits_q, hits_d, hits_new;
  logic [KEY_W-1:0] first_q, first_d, first_new;
  logic [2:0]       lows, hits_sum;
  logic             frame_end;
  kpd_frame_res_e   frame_res;

  always_comb begin
    lows      = count_low(col_s_q);
    hits_sum  = {1'b0, hits_q} + lows;
    hits_new  = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    // Only the first hit of a frame is recorded; with one hit it is the key.
    first_new = (hits_q == 2'd0 && lows != 3'd0)
              ? {row_idx_q, lowest_low(col_s_q)} : first_q;
    frame_end = tick && (row_idx_q == 2'd3);

    case (hits_new)
      2'd0:    frame_res = NONE;
      2'd1:    frame_res = KEY;
      default: frame_res = MULTI;
    endcase

    hits_d  = hits_q;
    first_d = first_q;
    if (frame_end) begin
      hits_d  = '0;
      first_d = '0;
    end else if (tick) begin
      hits_d  = hits_new;
      first_d = first_new;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_idx_q <= '0;
      hits_q    <= '0;
      first_q   <= '0;
    end else begin
      row_idx_q <= row_idx_d;
      hits_q    <= hits_d;
      first_q   <= first_d;
    end
  end

  // ------------------------------------------------------- debounce FSM
  kpd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             down_q, down_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      down_q  <= down_d;
    end
  end

  // Next-state logic; the FSM only moves on a frame-end tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    down_d  = down_q;
    cnt_inc = (cnt_q == DB_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_res == KEY) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = PRESSED;
              code_d  = first_new;
              valid_d = 1'b1;
              down_d  = 1'b1;
              cnt_d   = '0;
            end else begin
              state_d = PRESS_DB;
              cand_d  = first_new;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        PRESS_DB: begin
          if (frame_res == KEY && first_new == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              down_d  = 1'b1;
            end
          end else if (frame_res == KEY) begin
            cand_d = first_new;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        PRESSED: begin
          // Rollover: any KEY or MULTI while held is ignored.
          if (frame_res == NONE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = IDLE;
              down_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = REL_DB;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        REL_DB: begin
          if (frame_res == NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_MAX) begin
              state_d = IDLE;
              down_d  = 1'b0;
              cnt_d   = '0;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs (all registered upstream)
  always_comb begin
    key_code  = code_q;
    key_valid = valid_q;
    key_down  = down_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan with DIV=4 (16-cycle
// frames) and DEBOUNCE_FRAMES=2. A keypad model ties held keys to the row
// drive; key sets change only at frame boundaries. The reference model works
// per frame: it classifies the held set and tracks run lengths of identical
// frame results to decide press acceptance and release.
module tb_keypad_scan;

  localparam int DB    = 2;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]          col, row, key_code;
  logic                key_valid, key_down;
  kpd_pkg::kpd_state_e dbg_state;
  logic [15:0]         held;

  keypad_scan #(
    .CLK_FREQ        (16),
    .SCAN_FREQ       (4),
    .DEBOUNCE_FRAMES (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down),
    .dbg_state (dbg_state)
  );

  // Keypad: key (r,c) held pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && held[r*4+c]) col[c] = 1'b0;
  end

  // ------------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_q[$];

  int         edge_n;
  int         prev_res;
  int         run_len;
  bit         m_down;
  bit         m_valid;
  logic [3:0] m_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
  endtask

  // -1 = no key, 16 = several keys, otherwise the key code r*4+c.
  function automatic int frame_result(input logic [15:0] h);
    int n;
    n = $countones(h);
    if (n == 0) return -1;
    if (n >= 2) return 16;
    for (int i = 0; i < 16; i++) if (h[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    prev_res = -1;
    run_len  = 0;
    m_down   = 0;
    m_valid  = 0;
    m_code   = '0;
    exp_q.delete();
  endtask

  task automatic model_frame_end();
    int res;
    res = frame_result(held);
    if (res == prev_res) begin
      if (run_len < 1000) run_len++;
    end else begin
      run_len = 1;
    end
    prev_res = res;
    if (!m_down && res >= 0 && res < 16 && run_len == DB) begin
      m_down  = 1;
      m_code  = 4'(res);
      m_valid = 1;
      exp_q.push_back(m_code);
    end else if (m_down && res < 0 && run_len == DB) begin
      m_down = 0;
    end
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic step();
    logic [3:0] er;
    @(posedge clk);
    edge_n++;
    m_valid = 0;
    if (edge_n % FRAME == 0) model_frame_end();
    @(negedge clk);
    er = ~(4'b0001 << ((edge_n / DIV) % 4));
    check("row", row, er);
    check("key_valid", key_valid, m_valid);
    check("key_down", key_down, m_down);
    check("key_code", key_code, m_code);
    if (key_valid && exp_q.size() > 0) check("event_code", key_code, exp_q.pop_front());
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic run_frames(input int n);
    run_cycles(n * FRAME);
  endtask

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] one;
    one = 16'h0001;
    return one << (r * 4 + c);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_row", row, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_down", key_down, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_state", 32'(dbg_state), 32'(kpd_pkg::IDLE));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    edge_n = 0;
  endtask

  // ------------------------------------------------------ stimulus
  initial begin
    held = '0;
    #2;
    do_reset();

    // Idle scanning
    run_frames(10);

    // Single key (2,1) held 5 frames, then released
    held = key_bit(2, 1);
    run_frames(5);
    held = '0;
    run_frames(4);

    // Short press (0,3): one frame only
    held = key_bit(0, 3);
    run_frames(1);
    held = '0;
    run_frames(3);

    // Chord (1,0)+(1,2)
    held = key_bit(1, 0) | key_bit(1, 2);
    run_frames(4);
    held = '0;
    run_frames(3);

    // Press/release (2,1), then press (0,3)
    held = key_bit(2, 1);
    run_frames(3);
    held = '0;
    run_frames(3);
    held = key_bit(0, 3);
    run_frames(3);
    held = '0;
    run_frames(3);

    // Reset during press debounce, then a fresh full press
    held = key_bit(2, 1);
    run_cycles(FRAME + int'($urandom_range(1, FRAME - 1)));
    do_reset();
    run_frames(3);
    held = '0;
    run_frames(3);

    // Randomised key activity
    for (int i = 0; i < 24; i++) begin
      int kind, a, b;
      kind = int'($urandom_range(0, 3));
      a    = int'($urandom_range(0, 15));
      b    = (a + int'($urandom_range(1, 15))) % 16;
      case (kind)
        0, 1: held = '0;
        2:    held = key_bit(a / 4, a % 4);
        default: held = key_bit(a / 4, a % 4) | key_bit(b / 4, b % 4);
      endcase
      run_frames(int'($urandom_range(1, 4)));
    end
    held = '0;
    run_frames(3);

    check("events_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
